// File: rtl/fwd_hazard_unit_if.sv
// ID <-> forwarding/hazard unit bundle.
// The master side (ID stage) drives the issue and read-port requests.
// The slave side (fwd_hazard_unit) returns the resolved operands and the stall.
interface fwd_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int NRP    = 2,
  parameter int DEPTH  = 3
);
  logic                           id_issue;
  logic [4:0]                     id_wr_addr;
  logic [1:0]                     id_tnew;
  logic [NRP-1:0][4:0]            id_rd_addr;
  logic [NRP-1:0]                 id_rd_use;
  logic [NRP-1:0][DATA_W-1:0]     rf_rdata;
  logic [DEPTH-1:0][DATA_W-1:0]   stage_data;
  logic [NRP-1:0][DATA_W-1:0]     fwd_data;
  logic [NRP-1:0][1:0]            fwd_sel;
  logic                           stall;

  modport master (
    output id_issue, id_wr_addr, id_tnew, id_rd_addr, id_rd_use,
           rf_rdata, stage_data,
    input  fwd_data, fwd_sel, stall
  );

  modport slave (
    input  id_issue, id_wr_addr, id_tnew, id_rd_addr, id_rd_use,
           rf_rdata, stage_data,
    output fwd_data, fwd_sel, stall
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding + stall controller for the 5-stage MIPS pipeline (sits beside ID).
// A scoreboard shift register tracks in-flight writes in EX/MEM/WB; each ID
// read port picks the youngest matching entry and either forwards that stage's
// result or requests a stall if the value is not produced yet.
// Optional feature macro: FWD_HILO_EN adds a mult/div busy counter and
// HI/LO read stalls (ports md_start, hilo_rd, md_busy).

// Per-read-port lookup: youngest (lowest index) matching entry wins, even when
// it is not ready yet, so an older ready copy never leaks through.
module fwd_hazard_port #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 3
) (
  input  logic [4:0]                   rd_addr,
  input  logic                         rd_use,
  input  logic [DATA_W-1:0]            rf_rdata,
  input  logic [DEPTH-1:0]             sb_vld,
  input  logic [DEPTH-1:0][4:0]        sb_addr,
  input  logic [DEPTH-1:0][1:0]        sb_tnew,
  input  logic [DEPTH-1:0][DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]            fwd_data,
  output logic [1:0]                   fwd_sel,
  output logic                         stall_req
);
  logic pend;

  // Scan oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    fwd_data = rf_rdata;
    fwd_sel  = 2'd0;
    pend     = 1'b0;
    if (rd_addr != 5'd0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (sb_vld[k] && (sb_addr[k] == rd_addr)) begin
          fwd_data = stage_data[k];
          fwd_sel  = 2'(k + 1);
          pend     = (sb_tnew[k] != 2'd0);
        end
      end
    end
    stall_req = pend & rd_use;
  end
endmodule

module fwd_hazard_unit #(
  parameter int DATA_W = 32,
  parameter int NRP    = 2,
  parameter int DEPTH  = 3,
  parameter int MD_LAT = 5
) (
  input  logic              clk,
  input  logic              reset,
  fwd_hazard_unit_if.slave  bus
`ifdef FWD_HILO_EN
  ,
  input  logic              md_start,
  input  logic              hilo_rd,
  output logic              md_busy
`endif
);
  // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB.
  logic [DEPTH-1:0]          sb_vld_q, sb_vld_d;
  logic [DEPTH-1:0][4:0]     sb_addr_q, sb_addr_d;
  logic [DEPTH-1:0][1:0]     sb_tnew_q, sb_tnew_d;

  logic [NRP-1:0]              stall_req;
  logic [NRP-1:0][DATA_W-1:0]  fwd_data;
  logic [NRP-1:0][1:0]         fwd_sel;
  logic                        reg_stall;
  logic                        stall;
  logic                        issue_ok;

  // One lookup instance per read port.
  for (genvar gp = 0; gp < NRP; gp++) begin : g_port
    fwd_hazard_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .rd_addr    (bus.id_rd_addr[gp]),
      .rd_use     (bus.id_rd_use[gp]),
      .rf_rdata   (bus.rf_rdata[gp]),
      .sb_vld     (sb_vld_q),
      .sb_addr    (sb_addr_q),
      .sb_tnew    (sb_tnew_q),
      .stage_data (bus.stage_data),
      .fwd_data   (fwd_data[gp]),
      .fwd_sel    (fwd_sel[gp]),
      .stall_req  (stall_req[gp])
    );
  end

  assign reg_stall = |stall_req;

`ifdef FWD_HILO_EN
  localparam int CW = $clog2(MD_LAT + 1);
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // Busy countdown; a new start (even while busy) reloads the full latency.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start)
      md_cnt_d = CW'(MD_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - CW'(1);
  end

  // Busy counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_busy = (md_cnt_q != '0);
  assign stall   = reg_stall | (hilo_rd & (md_busy | md_start));
`else
  assign stall   = reg_stall;
`endif

  assign issue_ok = bus.id_issue & ~stall;

  // Scoreboard shift: new entry (or bubble) into EX, others age by one stage
  // with tnew counting down to zero.
  always_comb begin
    sb_vld_d     = '0;
    sb_addr_d    = '0;
    sb_tnew_d    = '0;
    if (issue_ok && (bus.id_wr_addr != 5'd0)) begin
      sb_vld_d[0]  = 1'b1;
      sb_addr_d[0] = bus.id_wr_addr;
      sb_tnew_d[0] = bus.id_tnew;
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_vld_d[k]  = sb_vld_q[k-1];
      sb_addr_d[k] = sb_addr_q[k-1];
      sb_tnew_d[k] = (sb_tnew_q[k-1] == 2'd0) ? 2'd0 : sb_tnew_q[k-1] - 2'd1;
    end
  end

  // Scoreboard registers; reset clears every entry so nothing stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld_q  <= '0;
      sb_addr_q <= '0;
      sb_tnew_q <= '0;
    end else begin
      sb_vld_q  <= sb_vld_d;
      sb_addr_q <= sb_addr_d;
      sb_tnew_q <= sb_tnew_d;
    end
  end

  assign bus.fwd_data = fwd_data;
  assign bus.fwd_sel  = fwd_sel;
  assign bus.stall    = stall;
endmodule
